// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) to single-memory arbiter with round-robin
// tie-break, enable/ack handshake sequencing and a per-access timeout.
module mem_arbiter #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       WAIT_MAX = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  port_t      owner;
  port_t      last_grant;
  logic [7:0] wait_cnt;
  logic       d_wins;
  logic       unused_addr_bits;

  // Only the low ADDR_W address bits reach the memory.
  assign unused_addr_bits = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  // Data wins when it is the only requester, or on a tie when instruction went last.
  always_comb begin
    d_wins = d_req && (!i_req || last_grant == PORT_I);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= PORT_I;
      last_grant  <= PORT_I;
      wait_cnt    <= '0;
      m_en        <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner      <= d_wins ? PORT_D : PORT_I;
            last_grant <= d_wins ? PORT_D : PORT_I;
            m_addr     <= d_wins ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
            m_wdata    <= d_wins ? d_wdata : '0;
            m_we       <= d_wins && d_we;
            m_en       <= 1'b1;
            busy       <= 1'b1;
            wait_cnt   <= '0;
            state      <= GRANT;
          end
        end

        GRANT: begin
          // An ack on the last allowed cycle takes priority over the timeout.
          if (m_ack || wait_cnt == WAIT_LAST) begin
            if (owner == PORT_D) begin
              d_rdata <= m_ack ? m_rdata : ERR_DATA;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= m_ack ? m_rdata : ERR_DATA;
              i_ack   <= 1'b1;
            end
            if (!m_ack) timeout_err <= 1'b1;
            m_en  <= 1'b0;
            m_we  <= 1'b0;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level arbitration/timing model.
module tb_mem_arbiter;

  localparam int unsigned WAIT_MAX = 15;
  localparam logic [31:0] ERR      = 32'hDEADBEEF;
  localparam logic [31:0] MASK     = 32'h0000_03FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [31:0] i_rdata, d_rdata, m_wdata;
  logic [9:0]  m_addr;
  logic        i_ack, d_ack, m_en, m_we, busy, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          last_d;
  bit          exp_terr;
  logic [31:0] exp_i_rd, exp_d_rd;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .WAIT_MAX(WAIT_MAX), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".m_en"}, m_en, 0);
    chk({tag, ".m_we"}, m_we, 0);
    chk({tag, ".i_ack"}, i_ack, 0);
    chk({tag, ".d_ack"}, d_ack, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".timeout_err"}, timeout_err, 0);
    chk({tag, ".m_addr"}, m_addr, 0);
    chk({tag, ".m_wdata"}, m_wdata, 0);
    chk({tag, ".i_rdata"}, i_rdata, 0);
    chk({tag, ".d_rdata"}, d_rdata, 0);
  endtask

  task automatic model_reset();
    last_d   = 1'b0;
    exp_terr = 1'b0;
    exp_i_rd = '0;
    exp_d_rd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_reset();
    chk_zero("reset");
  endtask

  // Runs one transaction starting in an IDLE cycle. lat = GRANT cycle index in
  // which the memory acks (>= WAIT_MAX means never). Ends in the following IDLE cycle.
  task automatic txn(input bit ireq, input bit dreq, input logic [31:0] ia,
                     input bit we, input logic [31:0] da, input logic [31:0] wd,
                     input logic [31:0] rd, input int lat, input bit keep,
                     input bit perturb);
    bit          win_d, acked, done;
    logic [31:0] exp_addr;
    bit          exp_we;
    int          n;
    i_req = ireq; i_addr = ia;
    d_req = dreq; d_we = we; d_addr = da; d_wdata = wd;
    win_d    = dreq && (!ireq || !last_d);
    last_d   = win_d;
    exp_addr = (win_d ? da : ia) & MASK;
    exp_we   = win_d && we;
    step();
    n = 0; done = 1'b0; acked = 1'b0;
    while (!done) begin
      chk("grant.m_en", m_en, 1);
      chk("grant.m_addr", m_addr, exp_addr);
      chk("grant.m_we", m_we, exp_we);
      if (exp_we) chk("grant.m_wdata", m_wdata, wd);
      chk("grant.acks", {i_ack, d_ack}, 0);
      chk("grant.busy", busy, 1);
      if (perturb) d_addr = 32'h20;
      acked   = (n == lat);
      m_ack   = acked;
      m_rdata = acked ? rd : $urandom;
      step();
      m_ack   = 1'b0;
      m_rdata = $urandom;
      done    = acked || (n == int'(WAIT_MAX) - 1);
      n++;
    end
    if (!acked) exp_terr = 1'b1;
    if (win_d) exp_d_rd = acked ? rd : ERR;
    else       exp_i_rd = acked ? rd : ERR;
    chk("resp.i_ack", i_ack, !win_d);
    chk("resp.d_ack", d_ack, win_d);
    chk("resp.i_rdata", i_rdata, exp_i_rd);
    chk("resp.d_rdata", d_rdata, exp_d_rd);
    chk("resp.m_en", m_en, 0);
    chk("resp.busy", busy, 1);
    chk("resp.timeout_err", timeout_err, exp_terr);
    if (win_d) d_req = keep;
    else       i_req = keep;
    step();
    chk("idle.acks", {i_ack, d_ack}, 0);
    chk("idle.m_en", m_en, 0);
    chk("idle.busy", busy, 0);
  endtask

  initial begin
    bit          pi, pd, we_r, keep_r;
    logic [31:0] ia_r, da_r, wd_r;

    model_reset();
    do_reset();

    // Single fetch, memory acks in the first GRANT cycle
    txn(1, 0, 32'h004, 0, 0, 0, 32'h20080005, 0, 0, 0);

    // Data write, ack in the third GRANT cycle
    txn(0, 1, 0, 1, 32'h10, 32'hCAFEF00D, $urandom, 2, 0, 0);

    // Timeout on a data read, then sticky error across a good fetch
    txn(0, 1, 0, 0, 32'h44, 0, 0, 255, 0, 0);
    txn(1, 0, 32'h08, 0, 0, 0, 32'h12345678, 1, 0, 0);

    // Both ports held: D, I, D, I
    do_reset();
    txn(1, 1, 32'h100, 0, 32'h200, 32'h1, 32'hA0, 0, 1, 0);
    txn(1, 1, 32'h100, 0, 32'h200, 32'h1, 32'hA1, 1, 1, 0);
    txn(1, 1, 32'h100, 0, 32'h200, 32'h1, 32'hA2, 0, 1, 0);
    txn(1, 1, 32'h100, 0, 32'h200, 32'h1, 32'hA3, 3, 0, 0);
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Reset in the second GRANT cycle drops the transaction
    i_req = 1'b1; i_addr = 32'h3C;
    step();
    chk("rst_mid.g1", m_en, 1);
    step();
    chk("rst_mid.g2", m_en, 1);
    reset = 1'b1; i_req = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    chk_zero("rst_mid");
    step();
    chk_zero("rst_mid.after");
    txn(1, 0, 32'h3C, 0, 0, 0, 32'h0BADF00D, 0, 0, 0);

    // Requester address changes during GRANT must not reach the memory
    txn(0, 1, 0, 0, 32'h10, 0, 32'h55AA55AA, 3, 0, 1);
    d_addr = 32'h10;

    // Randomized traffic
    pi = 0; pd = 0; ia_r = '0; da_r = '0; we_r = 0; wd_r = '0;
    for (int t = 0; t < 40; t++) begin
      if (!pi) begin pi = 1'($urandom_range(0, 1)); ia_r = $urandom; end
      if (!pd) begin
        pd = 1'($urandom_range(0, 1)); da_r = $urandom;
        we_r = 1'($urandom_range(0, 1)); wd_r = $urandom;
      end
      if (!pi && !pd) begin pi = 1'b1; ia_r = $urandom; end
      keep_r = 1'($urandom_range(0, 1));
      txn(pi, pd, ia_r, we_r, da_r, wd_r, $urandom,
          int'($urandom_range(0, WAIT_MAX + 2)), keep_r, 0);
      if (last_d) begin
        pd = keep_r; da_r = $urandom; we_r = 1'($urandom_range(0, 1)); wd_r = $urandom;
      end else begin
        pi = keep_r; ia_r = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter. Lets the processor's instruction-fetch port and data port share a single `memory` instance in place of the split instruction/data memories. It grants one requester at a time using round-robin on ties, sequences the memory's enable/ack handshake, latches read data back to the winner, and aborts hung accesses with a timeout.

## Interface
Parameters:
- ADDR_W, 10, memory address width; `m_addr` takes `addr[ADDR_W-1:0]`.
- DATA_W, 32, data width.
- WAIT_MAX, 15, maximum GRANT cycles without `m_ack` before abort (1..255).
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- i_req  in  1  Instruction fetch request; held until `i_ack`.
- i_addr  in  32  Fetch address.
- i_rdata  out  DATA_W  Fetch data; valid while `i_ack`=1.
- i_ack  out  1  One-cycle completion pulse.
- d_req  in  1  Data request; held until `d_ack`.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  Data address.
- d_wdata  in  DATA_W  Write data.
- d_rdata  out  DATA_W  Read data; valid while `d_ack`=1.
- d_ack  out  1  One-cycle completion pulse.
- m_en  out  1  Memory access strobe; held high until `m_ack` or timeout.
- m_we  out  1  Memory write enable; qualified by `m_en`.
- m_addr  out  ADDR_W  Memory address.
- m_wdata  out  DATA_W  Memory write data.
- m_rdata  in  DATA_W  Memory read data; sampled in the `m_ack` cycle.
- m_ack  in  1  Memory completion; ignored unless `m_en`=1.
- busy  out  1  1 in GRANT or RESP.
- timeout_err  out  1  Sticky; set on any abort, cleared only by reset.

## Operation
- States: IDLE, GRANT, RESP.
- IDLE:
  - No request: stay.
  - Exactly one of `i_req`/`d_req` high: that requester wins.
  - Both high: winner is the port opposite `last_grant`.
  - On grant, register `owner`, `m_addr`, `m_wdata`, `m_we`, then go to GRANT. `m_we` = `d_we` for data and 0 for instruction.
  - Set `last_grant` to the winner. `last_grant` resets to I, so the first tie goes to D.
- GRANT:
  - `m_en`=1; address, data and `m_we` are stable from registers. Requester inputs are not re-sampled.
  - Wait counter starts at 0 on entry and increments each GRANT cycle.
  - `m_ack`=1: capture `m_rdata` into the owner's rdata register and go to RESP. `m_rdata` is captured on writes too.
  - Counter reaches WAIT_MAX-1 with no `m_ack`: load ERR_DATA into the owner's rdata, set `timeout_err`, go to RESP.
  - `m_ack` on the final allowed cycle counts as success.
- RESP: owner's ack=1 for exactly one cycle, `m_en`=0, then go to IDLE.
- After ack, the requester deasserts req in the next cycle or starts a new transaction. A req still high in the following IDLE cycle is a new request.
- The non-owner's rdata register holds its last value.
- `m_ack` outside GRANT is ignored.
- Reset mid-transaction:
  - State goes to IDLE and the transaction is dropped; no ack is issued.
  - `m_en`, `m_we`, `i_ack`, `d_ack`, `busy`, `timeout_err` = 0.
  - `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0.
  - `last_grant` = I, wait counter = 0.

## Timing
- Cycle 0 (IDLE, req sampled high) → cycle 1 GRANT with `m_en`=1.
- `m_ack` in cycle k ≥ 1 → ack in cycle k+1 → IDLE in cycle k+2.
- Minimum req→ack is 2 cycles (memory acks in the first GRANT cycle).
- Minimum period between back-to-back transactions is 3 cycles.
- Timeout: `m_en` high for exactly WAIT_MAX cycles, then ack one cycle later with ERR_DATA.
- Both ports held continuously high: grants alternate D, I, D, I…; neither waits more than one transaction.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then `i_req`=1, `i_addr`=0x004, memory acks in the first GRANT cycle with 0x20080005 → `m_addr`=0x004 and `m_we`=0 in cycle 1; `i_ack`=1 with `i_rdata`=0x20080005 in cycle 2; `d_ack` stays 0.
- `d_req`=1, `d_we`=1, `d_addr`=0x10, `d_wdata`=0xCAFEF00D, memory acks after 3 cycles → `m_we`=1, `m_wdata`=0xCAFEF00D held for 3 GRANT cycles; `d_ack` 1 cycle after `m_ack`.
- Both requests asserted together after reset and held, 4 transactions → grant order D, I, D, I; each ack is exactly one cycle.
- Memory never acks, WAIT_MAX=15 → `m_en` high 15 cycles, then `d_ack`=1 with `d_rdata`=0xDEADBEEF, `timeout_err`=1 and staying 1 on later good transactions.
- Reset asserted in the 2nd GRANT cycle → next cycle all outputs 0, state IDLE, no ack; a fresh `i_req` completes normally.
- Change `d_addr` from 0x10 to 0x20 during GRANT → `m_addr` stays 0x10 until completion.
